// File: rtl/cla_tb_pkg.sv
// Shared types and helpers for the CLA test path.
// Holds the checker FSM encoding and the Galois MISR step.
package cla_tb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [7:0] ERR_NONE  = 8'hFF;
    localparam int         MISR_MAXW = 32;

    // One Galois MISR step on the low m bits; upper bits of the result are zero.
    function automatic logic [MISR_MAXW-1:0] misr_next(
        input logic [MISR_MAXW-1:0] sig,
        input logic [MISR_MAXW-1:0] d,
        input logic [MISR_MAXW-1:0] poly,
        input int                   m
    );
        logic                 t;
        logic [MISR_MAXW-1:0] nx;
        t  = sig[5'(m - 1)];
        nx = '0;
        for (int i = 0; i < MISR_MAXW; i++) begin
            if (i == 0) begin
                nx[i] = t ^ d[i];
            end else if (i < m) begin
                nx[i] = sig[i-1] ^ (poly[i] & t) ^ d[i];
            end
        end
        return nx;
    endfunction

endpackage

// File: rtl/misr_reg.sv
// M-bit Galois MISR with synchronous load and enable.
// Shared between the response checker and the LFSR labs.
module misr_reg
    import cla_tb_pkg::*;
#(
    parameter int           M    = 5,
    parameter logic [M-1:0] POLY = 5'b00101,
    parameter logic [M-1:0] SEED = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [M-1:0] d,
    output logic [M-1:0] sig
);

    logic [M-1:0] sig_q;
    logic [M-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (load) begin
            sig_d = SEED;
        end else if (en) begin
            sig_d = M'(misr_next(32'(sig_q), 32'(d), 32'(POLY), M));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/cla_resp_checker.sv
// Response checker for the CLA lab: golden-add compare, MISR
// compaction and mismatch bookkeeping over one run of NUM_VEC beats.
module cla_resp_checker
    import cla_tb_pkg::*;
#(
    parameter int             WIDTH   = 4,
    parameter int             NUM_VEC = 20,
    parameter logic [WIDTH:0] POLY    = 5'b00101,
    parameter logic [WIDTH:0] SEED    = 5'b00000,
    parameter logic [WIDTH:0] GOLDEN  = 5'b00000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    input  logic             cin,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   signature,
    output logic [7:0]       err_cnt,
    output logic [7:0]       first_err,
    output logic             pass
);

    localparam int M = WIDTH + 1;

    state_e       state_q, state_d;
    logic [7:0]   vec_q, vec_d;
    logic [7:0]   err_q, err_d;
    logic [7:0]   fe_q, fe_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic [M-1:0] resp;
    logic [M-1:0] gold;
    logic         mism;
    logic         beat;
    logic         clr;

    assign resp = {cout, sum};
    assign gold = {1'b0, ain} + {1'b0, bin} + M'(cin);
    assign mism = resp != gold;
    assign beat = (state_q == RUN) && in_valid;
    // A start beat outside RUN only clears; its data is dropped.
    assign clr  = start && (state_q != RUN);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        err_d   = err_q;
        fe_d    = fe_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    vec_d   = '0;
                    err_d   = '0;
                    fe_d    = ERR_NONE;
                end
            end
            RUN: begin
                if (in_valid) begin
                    vec_d = vec_q + 8'd1;
                    if (mism) begin
                        if (err_q != 8'hFF) err_d = err_q + 8'd1;
                        if (fe_q == ERR_NONE) fe_d = vec_q;
                    end
                    if (vec_q == 8'(NUM_VEC - 1)) state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d == RUN;
        done_d = state_d == DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            err_q   <= '0;
            fe_q    <= ERR_NONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            fe_q    <= fe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    misr_reg #(
        .M    (M),
        .POLY (POLY),
        .SEED (SEED)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .load (clr),
        .en   (beat),
        .d    (resp),
        .sig  (signature)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign err_cnt   = err_q;
    assign first_err = fe_q;
    assign pass      = done_q && (err_q == 8'd0) && (signature == GOLDEN);

endmodule
